// File: rtl/shell_pkg.sv
// ---------------------------------------------------------------------------
// shell_pkg
// Definitions shared by the UART command shell (receive/decode side and the
// response transmitter).
//   KIND_*    : response kind encodings carried on i_Resp_Kind
//   CR, LF    : line terminator characters
//   hexAscii  : maps a 4-bit nibble to its uppercase ASCII hex digit
// ---------------------------------------------------------------------------
package shell_pkg;

    localparam logic [1:0] KIND_DATA = 2'd0;
    localparam logic [1:0] KIND_OK   = 2'd1;
    localparam logic [1:0] KIND_ERR  = 2'd2;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    // '0'..'9' for 0..9, 'A'..'F' for 10..15 ('A' - 10 = 0x37).
    function automatic logic [7:0] hexAscii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end else begin
            return 8'h37 + {4'h0, nib};
        end
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// ---------------------------------------------------------------------------
// uart_tx_core
// 8N1 serialiser: start bit (0), 8 data bits LSB first, stop bit (1), each
// held for CLKS_PER_BIT clocks. CLKS_PER_BIT must be at least 2.
//   CLK, RST    : clock, asynchronous active-high reset
//   i_TX_DV     : byte strobe, taken only while the core is idle
//   i_TX_Byte   : byte to send
//   o_TX_Serial : serial line, idle high
//   o_TX_Active : a frame is on the line
//   o_TX_Done   : one-cycle pulse near the end of the stop bit
// ---------------------------------------------------------------------------
module uart_tx_core #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Serial,
    output logic       o_TX_Active,
    output logic       o_TX_Done
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(CLKS_PER_BIT - 2);

    logic [9:0]       shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic             active_q, active_d;

    // The whole frame lives in a shift register that refills with ones, so
    // the line output is simply bit 0 and returns high when the frame ends
    // or the register is reset.
    always_comb begin
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        active_d = active_q;
        if (!active_q) begin
            if (i_TX_DV) begin
                shift_d  = {1'b1, i_TX_Byte, 1'b0};
                cnt_d    = '0;
                bit_d    = '0;
                active_d = 1'b1;
            end
        end else if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            shift_d = {1'b1, shift_q[9:1]};
            if (bit_q == 4'd9) begin
                active_d = 1'b0;
                bit_d    = '0;
            end else begin
                bit_d = bit_q + 4'd1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shift_q  <= '1;
            cnt_q    <= '0;
            bit_q    <= '0;
            active_q <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            active_q <= active_d;
        end
    end

    assign o_TX_Serial = shift_q[0];
    assign o_TX_Active = active_q;
    // Done fires in the second-to-last stop-bit cycle: the formatter needs
    // two clocks to reload a byte, so this lets the next start bit follow
    // the stop bit after a single idle cycle.
    assign o_TX_Done   = active_q && (bit_q == 4'd9) && (cnt_q == DONE_CNT);

endmodule

// File: rtl/shell_resp_tx.sv
// ---------------------------------------------------------------------------
// shell_resp_tx
// Formats one shell response (hex data word, "OK" or "ERR") as an ASCII line
// terminated by CR LF and sends it 8N1 on UART_TX.
//   CLK, RST      : clock, asynchronous active-high reset
//   i_Resp_Valid  : request present; accepted when o_Resp_Ready is high
//   o_Resp_Ready  : idle and able to accept a request (registered)
//   i_Resp_Kind   : 0 DATA, 1 OK, 2 ERR, 3 reserved (sent as ERR)
//   i_Resp_Data   : word printed for DATA, MSB nibble first
//   UART_TX       : serial line, idle high
//   o_Busy        : line in progress, inverse of o_Resp_Ready
// ---------------------------------------------------------------------------
module shell_resp_tx
    import shell_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_W       = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_Resp_Valid,
    output logic              o_Resp_Ready,
    input  logic [1:0]        i_Resp_Kind,
    input  logic [DATA_W-1:0] i_Resp_Data,
    output logic              UART_TX,
    output logic              o_Busy
);

    localparam int NDIG  = DATA_W / 4;
    localparam int MAXC  = (NDIG + 2 > 5) ? NDIG + 2 : 5;
    localparam int IDX_W = $clog2(MAXC);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [1:0]        kind_q, kind_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              txDv_q, txDv_d;
    logic [7:0]        txByte_q, txByte_d;
    logic              ready_q, ready_d;

    logic [7:0]        curChar;
    logic [IDX_W-1:0]  lastIdx;
    logic [3:0]        nib;
    logic              accept;
    logic              coreDone;
    logic              coreActive;

    assign accept = i_Resp_Valid && ready_q;

    // Character selected by the index for the latched kind, and the index
    // of the final character (LF) of that line.
    always_comb begin
        curChar = LF;
        lastIdx = IDX_W'(4);
        nib     = 4'h0;
        case (kind_q)
            KIND_DATA: begin
                lastIdx = IDX_W'(NDIG + 1);
                for (int k = 0; k < NDIG; k++) begin
                    if (int'(idx_q) == k) begin
                        nib = data_q[(NDIG-1-k)*4 +: 4];
                    end
                end
                if (int'(idx_q) < NDIG) begin
                    curChar = hexAscii(nib);
                end else if (int'(idx_q) == NDIG) begin
                    curChar = CR;
                end else begin
                    curChar = LF;
                end
            end
            KIND_OK: begin
                lastIdx = IDX_W'(3);
                case (int'(idx_q))
                    0:       curChar = 8'h4F;
                    1:       curChar = 8'h4B;
                    2:       curChar = CR;
                    default: curChar = LF;
                endcase
            end
            default: begin
                lastIdx = IDX_W'(4);
                case (int'(idx_q))
                    0:       curChar = 8'h45;
                    1:       curChar = 8'h52;
                    2:       curChar = 8'h52;
                    3:       curChar = CR;
                    default: curChar = LF;
                endcase
            end
        endcase
    end

    // Formatter FSM. The reserved kind is folded into ERR when latched so
    // the mux only ever sees three kinds.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        kind_d   = kind_q;
        data_d   = data_q;
        txDv_d   = 1'b0;
        txByte_d = txByte_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    kind_d  = (i_Resp_Kind == KIND_DATA || i_Resp_Kind == KIND_OK)
                              ? i_Resp_Kind : KIND_ERR;
                    data_d  = i_Resp_Data;
                end
            end
            LOAD: begin
                txDv_d   = 1'b1;
                txByte_d = curChar;
                state_d  = WAIT;
            end
            WAIT: begin
                if (coreDone) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = (idx_q < lastIdx) ? LOAD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // The final done arrives one cycle before the last stop bit ends;
        // ready stays low through that remaining stop cycle.
        ready_d = (state_d == IDLE) && !(coreActive && state_q == WAIT);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            kind_q   <= KIND_DATA;
            data_q   <= '0;
            txDv_q   <= 1'b0;
            txByte_q <= 8'hFF;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            kind_q   <= kind_d;
            data_q   <= data_d;
            txDv_q   <= txDv_d;
            txByte_q <= txByte_d;
            ready_q  <= ready_d;
        end
    end

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .CLK         (CLK),
        .RST         (RST),
        .i_TX_DV     (txDv_q),
        .i_TX_Byte   (txByte_q),
        .o_TX_Serial (UART_TX),
        .o_TX_Active (coreActive),
        .o_TX_Done   (coreDone)
    );

    assign o_Resp_Ready = ready_q;
    assign o_Busy       = !ready_q;

endmodule

// File: tb/tb_shell_resp_tx.sv
// ---------------------------------------------------------------------------
// tb_shell_resp_tx
// Directed bench for shell_resp_tx at CLKS_PER_BIT=4, DATA_W=16. Expected
// line bytes are queued when a request is issued; a UART receive model on
// UART_TX pops and compares each decoded byte.
// ---------------------------------------------------------------------------
module tb_shell_resp_tx;
   import shell_pkg::*;

   localparam int CPB    = 4;
   localparam int DATA_W = 16;

   logic              CLK = 1'b0;
   logic              RST = 1'b0;
   logic              valid = 1'b0;
   logic [1:0]        kind = 2'b00;
   logic [DATA_W-1:0] data = '0;
   logic              ready;
   logic              tx;
   logic              busy;

   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;
   int         rxCount = 0;
   bit         rxIgnore = 1'b0;
   logic [7:0] expQ[$];
   int         startQ[$];

   shell_resp_tx #(
      .CLKS_PER_BIT(CPB),
      .DATA_W      (DATA_W)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .i_Resp_Valid(valid),
      .o_Resp_Ready(ready),
      .i_Resp_Kind (kind),
      .i_Resp_Data (data),
      .UART_TX     (tx),
      .o_Busy      (busy)
   );

   // Free-running clock and a cycle counter used for all latency checks.
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // UART receive model: samples mid-bit on falling clock edges and checks
   // every decoded byte against the head of the expected queue.
   initial begin : rxModel
      logic [7:0] rxByte;
      logic       stopBit;
      int         t0;
      forever begin
         @(negedge CLK);
         if (tx === 1'b0) begin
            t0 = cyc;
            repeat (6) @(negedge CLK);
            rxByte[0] = tx;
            for (int b = 1; b < 8; b++) begin
               repeat (4) @(negedge CLK);
               rxByte[b] = tx;
            end
            repeat (4) @(negedge CLK);
            stopBit = tx;
            if (!rxIgnore) begin
               rxCount++;
               startQ.push_back(t0);
               checkOutput("rxStopBit", int'(stopBit), 1);
               if (expQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL rxUnexpected: got 0x%0h expected no byte", rxByte);
               end else begin
                  checkOutput("rxByte", int'(rxByte), int'(expQ.pop_front()));
               end
            end
         end
      end
   end

   // Waits for ready, presents one request for a single accept edge, then
   // scribbles the inputs so the DUT must rely on its latched copy.
   task automatic applyStimulus(input logic [1:0] k, input logic [DATA_W-1:0] d, output int acc);
      int n = 0;
      while (ready !== 1'b1 && n < 3000) begin
         @(negedge CLK);
         n++;
      end
      if (ready !== 1'b1) begin
         checks++;
         errors++;
         $display("[TB] FAIL acceptTimeout: got ready=0 expected ready=1");
      end
      valid = 1'b1;
      kind  = k;
      data  = d;
      @(posedge CLK);
      @(negedge CLK);
      acc   = cyc;
      valid = 1'b0;
      kind  = 2'b11;
      data  = 16'h5A5A;
      checkOutput("readyDropAfterAccept", int'(ready), 0);
      checkOutput("busyAfterAccept", int'(busy), 1);
   endtask

   task automatic waitReady(input int acc, input int expLat, input string name);
      int n = 0;
      while (ready !== 1'b1 && n < 3000) begin
         @(negedge CLK);
         n++;
      end
      if (ready !== 1'b1) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: got timeout expected ready", name);
      end else begin
         checkOutput(name, cyc - acc, expLat);
      end
   endtask

   // First start bit two edges after accept, then one start every 41 cycles
   // (40 line cycles plus one idle cycle).
   task automatic checkStarts(input int acc, input int base, input int count);
      if (startQ.size() >= base + count) begin
         checkOutput("firstStartLatency", startQ[base] - acc, 2);
         for (int k = 1; k < count; k++) begin
            checkOutput("charSpacing", startQ[base+k] - startQ[base+k-1], 41);
         end
      end else begin
         checks++;
         errors++;
         $display("[TB] FAIL startCount: got %0d expected %0d", startQ.size() - base, count);
      end
   endtask

   initial begin : watchdog
      #300000;
      errors++;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence.
   initial begin : mainSeq
      int acc;
      int acc2;
      int bad;
      int n;

      #1 RST = 1'b1;
      repeat (3) @(negedge CLK);
      RST = 1'b0;

      checkOutput("resetTx", int'(tx), 1);
      checkOutput("resetReady", int'(ready), 1);
      checkOutput("resetBusy", int'(busy), 0);
      bad = 0;
      repeat (1000) begin
         @(negedge CLK);
         if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) bad++;
      end
      checkOutput("idleHoldCycles", bad, 0);
      checkOutput("idleRxCount", rxCount, 0);

      $display("[TB] DATA 0x00A7");
      startQ.delete();
      expQ.push_back(8'h30); expQ.push_back(8'h30); expQ.push_back(8'h41);
      expQ.push_back(8'h37); expQ.push_back(8'h0D); expQ.push_back(8'h0A);
      applyStimulus(KIND_DATA, 16'h00A7, acc);
      waitReady(acc, 247, "dataReadyLatency");
      checkStarts(acc, 0, 6);

      $display("[TB] OK");
      startQ.delete();
      expQ.push_back(8'h4F); expQ.push_back(8'h4B);
      expQ.push_back(8'h0D); expQ.push_back(8'h0A);
      applyStimulus(KIND_OK, 16'hFFFF, acc);
      waitReady(acc, 165, "okReadyLatency");
      checkStarts(acc, 0, 4);

      $display("[TB] reserved kind 3, data 0x1234");
      startQ.delete();
      expQ.push_back(8'h45); expQ.push_back(8'h52); expQ.push_back(8'h52);
      expQ.push_back(8'h0D); expQ.push_back(8'h0A);
      applyStimulus(2'd3, 16'h1234, acc);
      waitReady(acc, 206, "errReadyLatency");
      checkStarts(acc, 0, 5);

      $display("[TB] DATA 0xBEEF then 0xFFFF held valid");
      startQ.delete();
      expQ.push_back(8'h42); expQ.push_back(8'h45); expQ.push_back(8'h45);
      expQ.push_back(8'h46); expQ.push_back(8'h0D); expQ.push_back(8'h0A);
      expQ.push_back(8'h46); expQ.push_back(8'h46); expQ.push_back(8'h46);
      expQ.push_back(8'h46); expQ.push_back(8'h0D); expQ.push_back(8'h0A);
      applyStimulus(KIND_DATA, 16'hBEEF, acc);
      repeat (100) @(negedge CLK);
      checkOutput("readyMidFrame", int'(ready), 0);
      valid = 1'b1;
      kind  = KIND_DATA;
      data  = 16'hFFFF;
      n = 0;
      while (ready !== 1'b1 && n < 3000) begin
         @(negedge CLK);
         n++;
      end
      checkOutput("heldReadyLatency", cyc - acc, 247);
      @(posedge CLK);
      @(negedge CLK);
      acc2  = cyc;
      valid = 1'b0;
      checkOutput("heldAcceptCycle", acc2 - acc, 248);
      checkOutput("heldReadyDrop", int'(ready), 0);
      waitReady(acc2, 247, "secondReadyLatency");
      checkStarts(acc, 0, 6);
      checkStarts(acc2, 6, 6);

      $display("[TB] reset during third character of DATA 0x1234");
      startQ.delete();
      expQ.push_back(8'h31); expQ.push_back(8'h32);
      applyStimulus(KIND_DATA, 16'h1234, acc);
      repeat (101) @(negedge CLK);
      checkOutput("txLowBeforeReset", int'(tx), 0);
      rxIgnore = 1'b1;
      #1 RST = 1'b1;
      #1;
      checkOutput("txHighOnReset", int'(tx), 1);
      checkOutput("readyOnReset", int'(ready), 1);
      checkOutput("busyOnReset", int'(busy), 0);
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      repeat (60) @(negedge CLK);
      rxIgnore = 1'b0;
      checkOutput("readyAfterRelease", int'(ready), 1);
      checkOutput("rxCountBeforeC0DE", rxCount, 29);
      checkOutput("expQEmptyAfterReset", expQ.size(), 0);

      $display("[TB] DATA 0xC0DE after reset");
      startQ.delete();
      expQ.push_back(8'h43); expQ.push_back(8'h30); expQ.push_back(8'h44);
      expQ.push_back(8'h45); expQ.push_back(8'h0D); expQ.push_back(8'h0A);
      applyStimulus(KIND_DATA, 16'hC0DE, acc);
      waitReady(acc, 247, "c0deReadyLatency");
      checkStarts(acc, 0, 6);

      repeat (20) @(negedge CLK);
      checkOutput("expQDrained", expQ.size(), 0);
      checkOutput("rxCountTotal", rxCount, 35);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
